// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Responder for the MEM-stage memory interface. A load or store presented by
// the MEM stage is accepted while idle. It completes a fixed LATENCY cycles
// later with a one-cycle ack_o pulse. While the access is in flight, stall_o
// holds the upstream pipeline registers. The word-addressed data RAM lives
// inside this block.
//
// Parameters
//   DEPTH    number of 32-bit RAM words (power of two)
//   LATENCY  cycles from request seen to ack_o (>= 1)
//
// Ports
//   clk_i       in   clock, all state changes on the rising edge
//   rst_i       in   synchronous active-high reset
//   MemRead_i   in   load request from the MEM stage
//   MemWrite_i  in   store request from the MEM stage
//   addr_i      in   byte address (ALU result)
//   data_i      in   store data
//   data_o      out  load data, valid while ack_o is high
//   stall_o     out  pipeline hold while a request is being serviced
//   ack_o       out  one-cycle completion pulse
//   err_o       out  request rejected (misaligned, out of range, both ops)
// ---------------------------------------------------------------------------
module data_memory_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = $clog2(LATENCY) + 1;
    localparam logic [31:0] LIMIT  = 32'(4 * DEPTH);
    localparam bit          SINGLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Request captured at acceptance, consumed when the access fires
    logic            op_read;
    logic            op_write;
    logic            op_err;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_data;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            req_err;
    logic [AW-1:0]   req_idx;

    logic            acc_read;
    logic            acc_write;
    logic            acc_err;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_data;
    logic            do_access;
    logic            mem_we;

    // Decode of the incoming request. The error check is evaluated only at
    // acceptance and then latched. This means later changes on the inputs
    // while BUSY cannot alter the outcome. Out-of-range addresses would
    // otherwise alias onto low words through the truncated index, so the
    // range check is what keeps them away from the RAM.
    assign req     = MemRead_i | MemWrite_i;
    assign req_err = (addr_i[1:0] != 2'b00) || (addr_i >= LIMIT) ||
                     (MemRead_i & MemWrite_i);
    assign req_idx = addr_i[AW+1:2];

    // Source of the access that fires on the edge entering RESP. With a
    // single-cycle latency the access happens directly out of IDLE. In that
    // case it must use the live inputs. Otherwise it uses the latched copy.
    always_comb begin
        acc_read  = op_read;
        acc_write = op_write;
        acc_err   = op_err;
        acc_idx   = op_idx;
        acc_data  = op_data;
        if (state == IDLE) begin
            acc_read  = MemRead_i;
            acc_write = MemWrite_i;
            acc_err   = req_err;
            acc_idx   = req_idx;
            acc_data  = data_i;
        end
    end

    // The access fires on the transition into RESP. Reset has priority, so a
    // request cancelled mid-flight never touches the RAM.
    always_comb begin
        do_access = 1'b0;
        if (!rst_i) begin
            if (state == IDLE && req && SINGLE) begin
                do_access = 1'b1;
            end else if (state == BUSY && cnt == CW'(1)) begin
                do_access = 1'b1;
            end
        end
        mem_we = do_access & acc_write & ~acc_err;
    end

    // Pipeline hold. While IDLE, the hold follows the request combinationally.
    // This freezes the upstream registers in the same cycle as the request.
    // It drops in RESP so the MEM stage advances on the edge leaving RESP.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = req;
            BUSY:    stall_o = 1'b1;
            RESP:    stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    // Data RAM. Its contents are deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

    // Main control FSM with registered ack/err/data outputs.
    // ack_o and err_o are pulsed together on the edge entering RESP and
    // cleared on every other edge. data_o only changes for loads. A store
    // leaves the previous load value in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            data_o   <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            op_read  <= 1'b0;
            op_write <= 1'b0;
            op_err   <= 1'b0;
            op_idx   <= '0;
            op_data  <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        op_read  <= MemRead_i;
                        op_write <= MemWrite_i;
                        op_err   <= req_err;
                        op_idx   <= req_idx;
                        op_data  <= data_i;
                        if (SINGLE) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_access) begin
                ack_o <= 1'b1;
                err_o <= acc_err;
                if (acc_read) begin
                    data_o <= acc_err ? 32'h0 : mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//
// Directed bench with two responders side by side:
//   dut_a: LATENCY=3 (the default configuration)
//   dut_b: LATENCY=1 (single-cycle latency)
//
// Both instances share the clock and reset. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        rd_a;
    logic        wr_a;
    logic [31:0] addr_a;
    logic [31:0] wdata_a;
    logic [31:0] rdata_a;
    logic        stall_a;
    logic        ack_a;
    logic        err_a;

    logic        rd_b;
    logic        wr_b;
    logic [31:0] addr_b;
    logic [31:0] wdata_b;
    logic [31:0] rdata_b;
    logic        stall_b;
    logic        ack_b;
    logic        err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(32), .LATENCY(3)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd_a),
        .MemWrite_i (wr_a),
        .addr_i     (addr_a),
        .data_i     (wdata_a),
        .data_o     (rdata_a),
        .stall_o    (stall_a),
        .ack_o      (ack_a),
        .err_o      (err_a)
    );

    data_memory_responder #(.DEPTH(32), .LATENCY(1)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd_b),
        .MemWrite_i (wr_b),
        .addr_i     (addr_b),
        .data_i     (wdata_b),
        .data_o     (rdata_b),
        .stall_o    (stall_b),
        .ack_o      (ack_b),
        .err_o      (err_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one request onto either the slow (a) or the fast (b) responder.
    task automatic applyStimulus(input bit fast, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        if (fast) begin
            rd_b    = rd;
            wr_b    = wr;
            addr_b  = addr;
            wdata_b = data;
        end else begin
            rd_a    = rd;
            wr_a    = wr;
            addr_a  = addr;
            wdata_a = data;
        end
    endtask

    // One complete LATENCY=3 transaction on dut_a, starting in an IDLE cycle T.
    // stall high T..T+2, ack at T+3, back in IDLE at T+4.
    task automatic runAccess(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic exp_err, input bit check_data,
                             input logic [31:0] exp_data);
        applyStimulus(1'b0, rd, wr, addr, data);
        #1;
        checkOutput({tag, " stall T"}, 32'(stall_a), 32'd1);
        checkOutput({tag, " ack T"}, 32'(ack_a), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput({tag, " stall T+1"}, 32'(stall_a), 32'd1);
        checkOutput({tag, " ack T+1"}, 32'(ack_a), 32'd0);
        tick();
        checkOutput({tag, " stall T+2"}, 32'(stall_a), 32'd1);
        checkOutput({tag, " ack T+2"}, 32'(ack_a), 32'd0);
        tick();
        checkOutput({tag, " ack T+3"}, 32'(ack_a), 32'd1);
        checkOutput({tag, " stall T+3"}, 32'(stall_a), 32'd0);
        checkOutput({tag, " err T+3"}, 32'(err_a), 32'(exp_err));
        if (check_data) begin
            checkOutput({tag, " data T+3"}, rdata_a, exp_data);
        end
        tick();
        checkOutput({tag, " ack T+4"}, 32'(ack_a), 32'd0);
        checkOutput({tag, " err T+4"}, 32'(err_a), 32'd0);
    endtask

    // Watchdog so the run always ends even if something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset in the middle of random traffic clears all outputs
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom),
                          32'($urandom_range(0, 40)) << 2, $urandom);
            applyStimulus(1'b1, 1'($urandom), 1'($urandom),
                          32'($urandom_range(0, 40)) << 2, $urandom);
            tick();
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst stall_a", 32'(stall_a), 32'd0);
        checkOutput("rst ack_a", 32'(ack_a), 32'd0);
        checkOutput("rst err_a", 32'(err_a), 32'd0);
        checkOutput("rst data_a", rdata_a, 32'h0);
        checkOutput("rst stall_b", 32'(stall_b), 32'd0);
        checkOutput("rst ack_b", 32'(ack_b), 32'd0);
        checkOutput("rst data_b", rdata_b, 32'h0);
        tick();

        // Store then load at the LATENCY=3 timing
        runAccess("st8", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        runAccess("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("data hold", rdata_a, 32'hDEADBEEF);

        // Misaligned load and out-of-range store
        runAccess("st0", 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'h0);
        runAccess("ld6", 1'b1, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0);
        runAccess("st80", 1'b0, 1'b1, 32'h80, 32'h22222222, 1'b1, 1'b0, 32'h0);
        runAccess("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11111111);

        // Reset during the second BUSY cycle cancels the store
        runAccess("st10a", 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'h12345678);
        #1;
        checkOutput("cancel stall T", 32'(stall_a), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("cancel ack T+3", 32'(ack_a), 32'd0);
        checkOutput("cancel stall T+3", 32'(stall_a), 32'd0);
        checkOutput("cancel data", rdata_a, 32'h0);
        tick();
        checkOutput("cancel ack T+4", 32'(ack_a), 32'd0);
        runAccess("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);

        // Read and write requested together is rejected
        runAccess("stC", 1'b0, 1'b1, 32'hC, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        runAccess("bothC", 1'b1, 1'b1, 32'hC, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
        runAccess("ldC", 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);

        // LATENCY=1 responder: store, then a held load acked once per accept
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 32'hCAFEF00D);
        #1;
        checkOutput("b st stall T", 32'(stall_b), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b st ack T+1", 32'(ack_b), 32'd1);
        checkOutput("b st err T+1", 32'(err_b), 32'd0);
        checkOutput("b st stall T+1", 32'(stall_b), 32'd0);
        tick();
        checkOutput("b st ack T+2", 32'(ack_b), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        checkOutput("b ld stall T", 32'(stall_b), 32'd1);
        checkOutput("b ld ack T", 32'(ack_b), 32'd0);
        tick();
        checkOutput("b ld ack T+1", 32'(ack_b), 32'd1);
        checkOutput("b ld stall T+1", 32'(stall_b), 32'd0);
        checkOutput("b ld data T+1", rdata_b, 32'hCAFEF00D);
        tick();
        checkOutput("b ld ack T+2", 32'(ack_b), 32'd0);
        checkOutput("b ld stall T+2", 32'(stall_b), 32'd1);
        tick();
        checkOutput("b ld ack T+3", 32'(ack_b), 32'd1);
        checkOutput("b ld stall T+3", 32'(stall_b), 32'd0);
        checkOutput("b ld data T+3", rdata_b, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("b ld ack T+4", 32'(ack_b), 32'd0);
        checkOutput("b ld stall T+4", 32'(stall_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
